// File: rtl/rle_zrun_sequencer.sv
// Zero-run sequencer ahead of the JPEG Huffman stage: turns 64 zig-zag coefficients into
// (run, size, amplitude) symbols with ZRL insertion and EOB. Define RLE_STATS_EN for per-block counters.
module rle_zrun_sequencer #(
  parameter int COEF_W  = 12,
  parameter int SIZE_W  = 4,
  parameter int BLK_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_rlen,
  output logic [SIZE_W-1:0] out_size,
  output logic [COEF_W-1:0] out_amp,
  output logic              out_dc,
  output logic              out_eob
`ifdef RLE_STATS_EN
  ,
  output logic [6:0]        stat_syms,
  output logic [1:0]        stat_zrl
`endif
);

  localparam int IDX_W = $clog2(BLK_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [COEF_W-1:0] COEF_ZERO = {COEF_W{1'b0}};

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ZRL    = 2'd1,
    ST_EOB    = 2'd2
  } state_t;

  function automatic logic [SIZE_W-1:0] coef_size(input logic [COEF_W-1:0] c);
    logic [COEF_W-1:0] mag;
    logic [SIZE_W-1:0] sz;
    mag = c[COEF_W-1] ? (~c + COEF_W'(1)) : c;
    // Only the most negative code still has its top bit set after negation; it is sized as the largest positive.
    mag = mag[COEF_W-1] ? {1'b0, {(COEF_W-1){1'b1}}} : mag;
    sz  = {SIZE_W{1'b0}};
    for (int i = 0; i < COEF_W; i++) begin
      sz = mag[i] ? SIZE_W'(i + 1) : sz;
    end
    return sz;
  endfunction

  function automatic logic [COEF_W-1:0] coef_amp(input logic [COEF_W-1:0] c);
    return c[COEF_W-1] ? (c - COEF_W'(1)) : c;
  endfunction

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          run_q, run_d;
  logic [1:0]          pend_q, pend_d;
  logic [COEF_W-1:0]   hold_coef_q, hold_coef_d;
  logic [3:0]          hold_run_q, hold_run_d;
  logic                out_valid_q, out_valid_d;
  logic [3:0]          out_rlen_q, out_rlen_d;
  logic [SIZE_W-1:0]   out_size_q, out_size_d;
  logic [COEF_W-1:0]   out_amp_q, out_amp_d;
  logic                out_dc_q, out_dc_d;
  logic                out_eob_q, out_eob_d;

  logic                slot_free_s, in_ready_s, accept_s;
  logic                emit_s, e_dc_s, e_eob_s;
  logic [3:0]          e_rlen_s;
  logic [COEF_W-1:0]   e_coef_s;

  // Next-state, run tracking and symbol selection; ZRL and EOB carry a zero coefficient.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_d       = run_q;
    pend_d      = pend_q;
    hold_coef_d = hold_coef_q;
    hold_run_d  = hold_run_q;
    emit_s      = 1'b0;
    e_rlen_s    = 4'd0;
    e_coef_s    = COEF_ZERO;
    e_dc_s      = 1'b0;
    e_eob_s     = 1'b0;
    slot_free_s = !out_valid_q || out_ready;
    in_ready_s  = (state_q == ST_ACCEPT) && slot_free_s;
    accept_s    = in_ready_s && in_valid;

    case (state_q)
      ST_ACCEPT: begin
        if (accept_s) begin
          idx_d = (idx_q == IDX_LAST) ? IDX_ZERO : (idx_q + IDX_W'(1));
          if (idx_q == IDX_ZERO) begin
            emit_s   = 1'b1;
            e_coef_s = in_coef;
            e_dc_s   = 1'b1;
            run_d    = 4'd0;
            pend_d   = 2'd0;
          end else if (in_coef == COEF_ZERO) begin
            if (idx_q == IDX_LAST) begin
              run_d   = 4'd0;
              pend_d  = 2'd0;
              state_d = ST_EOB;
            end else if (run_q != 4'd15) begin
              run_d = run_q + 4'd1;
            end else begin
              run_d  = 4'd0;
              pend_d = (pend_q == 2'd3) ? 2'd3 : (pend_q + 2'd1);
            end
          end else if (pend_q == 2'd0) begin
            emit_s   = 1'b1;
            e_rlen_s = run_q;
            e_coef_s = in_coef;
            run_d    = 4'd0;
          end else begin
            hold_coef_d = in_coef;
            hold_run_d  = run_q;
            run_d       = 4'd0;
            state_d     = ST_ZRL;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_ZRL: begin
        if (slot_free_s) begin
          emit_s = 1'b1;
          if (pend_q != 2'd0) begin
            e_rlen_s = 4'd15;
            pend_d   = pend_q - 2'd1;
          end else begin
            e_rlen_s = hold_run_q;
            e_coef_s = hold_coef_q;
            state_d  = ST_ACCEPT;
          end
        end else begin
          state_d = ST_ZRL;
        end
      end
      ST_EOB: begin
        if (slot_free_s) begin
          emit_s  = 1'b1;
          e_eob_s = 1'b1;
          state_d = ST_ACCEPT;
        end else begin
          state_d = ST_EOB;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase

    out_rlen_d = out_rlen_q;
    out_size_d = out_size_q;
    out_amp_d  = out_amp_q;
    out_dc_d   = out_dc_q;
    out_eob_d  = out_eob_q;
    if (emit_s) begin
      out_valid_d = 1'b1;
      out_rlen_d  = e_rlen_s;
      out_size_d  = coef_size(e_coef_s);
      out_amp_d   = coef_amp(e_coef_s);
      out_dc_d    = e_dc_s;
      out_eob_d   = e_eob_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output register; ena low freezes everything, reset wins over ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCEPT;
      idx_q       <= IDX_ZERO;
      run_q       <= 4'd0;
      pend_q      <= 2'd0;
      hold_coef_q <= COEF_ZERO;
      hold_run_q  <= 4'd0;
      out_valid_q <= 1'b0;
      out_rlen_q  <= 4'd0;
      out_size_q  <= {SIZE_W{1'b0}};
      out_amp_q   <= COEF_ZERO;
      out_dc_q    <= 1'b0;
      out_eob_q   <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      pend_q      <= pend_d;
      hold_coef_q <= hold_coef_d;
      hold_run_q  <= hold_run_d;
      out_valid_q <= out_valid_d;
      out_rlen_q  <= out_rlen_d;
      out_size_q  <= out_size_d;
      out_amp_q   <= out_amp_d;
      out_dc_q    <= out_dc_d;
      out_eob_q   <= out_eob_d;
    end
  end

  assign in_ready  = in_ready_s && ena && !rst;
  assign out_valid = out_valid_q;
  assign out_rlen  = out_rlen_q;
  assign out_size  = out_size_q;
  assign out_amp   = out_amp_q;
  assign out_dc    = out_dc_q;
  assign out_eob   = out_eob_q;

`ifdef RLE_STATS_EN
  logic [6:0] cnt_syms_q, cnt_syms_d, blk_syms_q, blk_syms_d, stat_syms_q, stat_syms_d;
  logic [1:0] cnt_zrl_q, cnt_zrl_d, blk_zrl_q, blk_zrl_d, stat_zrl_q, stat_zrl_d;
  logic       out_last_q, out_last_d;
  logic       zrl_s, last_s;

  // Per-block counts; the block total is staged at its last emit and published when that symbol leaves.
  always_comb begin
    cnt_syms_d  = cnt_syms_q;
    cnt_zrl_d   = cnt_zrl_q;
    blk_syms_d  = blk_syms_q;
    blk_zrl_d   = blk_zrl_q;
    out_last_d  = out_last_q;
    zrl_s       = emit_s && (e_rlen_s == 4'd15) && (e_coef_s == COEF_ZERO);
    // A non-DC coefficient emitted once idx has wrapped is the nonzero coefficient at the last position.
    last_s      = emit_s && (e_eob_s || ((idx_d == IDX_ZERO) && (e_coef_s != COEF_ZERO) && !e_dc_s));
    if (out_valid_q && out_ready && out_last_q) begin
      stat_syms_d = blk_syms_q;
      stat_zrl_d  = blk_zrl_q;
    end else begin
      stat_syms_d = stat_syms_q;
      stat_zrl_d  = stat_zrl_q;
    end
    if (emit_s) begin
      out_last_d = last_s;
      if (last_s) begin
        blk_syms_d = cnt_syms_q + 7'd1;
        blk_zrl_d  = cnt_zrl_q;
        cnt_syms_d = 7'd0;
        cnt_zrl_d  = 2'd0;
      end else begin
        cnt_syms_d = cnt_syms_q + 7'd1;
        cnt_zrl_d  = zrl_s ? (cnt_zrl_q + 2'd1) : cnt_zrl_q;
      end
    end else begin
      out_last_d = out_last_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_syms_q  <= 7'd0;
      cnt_zrl_q   <= 2'd0;
      blk_syms_q  <= 7'd0;
      blk_zrl_q   <= 2'd0;
      stat_syms_q <= 7'd0;
      stat_zrl_q  <= 2'd0;
      out_last_q  <= 1'b0;
    end else if (ena) begin
      cnt_syms_q  <= cnt_syms_d;
      cnt_zrl_q   <= cnt_zrl_d;
      blk_syms_q  <= blk_syms_d;
      blk_zrl_q   <= blk_zrl_d;
      stat_syms_q <= stat_syms_d;
      stat_zrl_q  <= stat_zrl_d;
      out_last_q  <= out_last_d;
    end
  end

  assign stat_syms = stat_syms_q;
  assign stat_zrl  = stat_zrl_q;
`endif

endmodule

// File: tb/tb_rle_zrun_sequencer.sv
// Bench for rle_zrun_sequencer: DC table vectors, hand-written corner blocks, and random
// blocks checked against a zero-count/divide reference model of the symbol stream.
module tb_rle_zrun_sequencer;

  logic        clk, rst, ena, in_valid, in_ready, out_valid, out_ready, out_dc, out_eob;
  logic [11:0] in_coef, out_amp;
  logic [3:0]  out_rlen, out_size;

  int checks   = 0;
  int failures = 0;
  int cur_blk[64];
  int stall_cnt;
  logic [21:0] exp_q[$];
  logic [21:0] got_q[$];
  logic [21:0] hold_sym;
  bit          hold_pend = 1'b0;

  typedef struct {
    int coef;
    int size;
    int amp;
  } dc_vec_t;
  dc_vec_t tbl[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rle_zrun_sequencer #(.COEF_W(12), .SIZE_W(4), .BLK_LEN(64)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rlen(out_rlen), .out_size(out_size), .out_amp(out_amp),
    .out_dc(out_dc), .out_eob(out_eob)
  );

  function automatic logic [21:0] mk(input int rlen, input int size, input int amp, input bit dc, input bit eob);
    return {rlen[3:0], size[3:0], amp[11:0], dc, eob};
  endfunction

  function automatic logic [21:0] cur_sym();
    return {out_rlen, out_size, out_amp, out_dc, out_eob};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference: bit length of |c|, with the most negative code sized like the largest positive.
  function automatic int m_size(input int c);
    int m;
    int s;
    m = (c < 0) ? -c : c;
    s = 0;
    while (m > 0) begin
      s++;
      m = m >> 1;
    end
    return (s > 11) ? 11 : s;
  endfunction

  function automatic int m_amp(input int c);
    return (c < 0) ? ((c - 1) & 32'h0000_0FFF) : c;
  endfunction

  task automatic model_block();
    int z;
    exp_q.push_back(mk(0, m_size(cur_blk[0]), m_amp(cur_blk[0]), 1'b1, 1'b0));
    z = 0;
    for (int k = 1; k < 64; k++) begin
      if (cur_blk[k] == 0) begin
        z++;
      end else begin
        for (int r = 0; r < z / 16; r++) exp_q.push_back(mk(15, 0, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(z % 16, m_size(cur_blk[k]), m_amp(cur_blk[k]), 1'b0, 1'b0));
        z = 0;
      end
    end
    if (cur_blk[63] == 0) exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b1));
  endtask

  // Output monitor: records handshakes and checks that a stalled symbol holds still.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("stall_hold", {9'd0, out_valid, cur_sym()}, {9'd0, 1'b1, hold_sym});
      if (ena && out_valid && out_ready) begin
        got_q.push_back(cur_sym());
        hold_pend = 1'b0;
      end else if (out_valid) begin
        hold_pend = 1'b1;
        hold_sym  = cur_sym();
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  // mode 0: ideal; mode 1: out_ready 1010.. with three ena-low cycles; other: random.
  task automatic drive_block(input int mode, input int first, input int last);
    int sent, cyc, off0, off1, off2;
    sent = first;
    cyc = 0;
    stall_cnt = 0;
    off0 = $urandom_range(0, 60);
    off1 = $urandom_range(0, 60);
    off2 = $urandom_range(0, 60);
    while ((sent < last || got_q.size() < exp_q.size() || out_valid) && cyc < 3000) begin
      @(posedge clk);
      #1;
      case (mode)
        0: begin
          ena = 1'b1; out_ready = 1'b1; in_valid = (sent < last);
        end
        1: begin
          out_ready = (cyc % 2 == 0);
          ena = !(cyc == off0 || cyc == off1 || cyc == off2);
          in_valid = (sent < last);
        end
        default: begin
          ena = ($urandom_range(0, 7) != 0);
          out_ready = ($urandom_range(0, 3) != 0);
          in_valid = (sent < last) && ($urandom_range(0, 3) != 0);
        end
      endcase
      in_coef = (sent < last) ? 12'(cur_blk[sent]) : 12'd0;
      @(negedge clk);
      if (ena && in_valid && !in_ready) stall_cnt++;
      if (ena && in_valid && in_ready) sent++;
      cyc++;
    end
    if (cyc >= 3000) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout sent=%0d got=%0d want=%0d", sent, got_q.size(), exp_q.size());
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic compare_block(input string name);
    int n;
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_sym%0d", name, i), {10'd0, got_q[i]}, {10'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_blk();
    for (int k = 0; k < 64; k++) cur_blk[k] = 0;
  endtask

  initial begin
    tbl[0] = '{5, 3, 5};
    tbl[1] = '{0, 0, 0};
    tbl[2] = '{-1, 1, 12'hFFE};
    tbl[3] = '{1, 1, 1};
    tbl[4] = '{-2048, 11, 12'h7FF};
    tbl[5] = '{2047, 11, 12'h7FF};
    tbl[6] = '{-3, 2, 12'hFFC};
    tbl[7] = '{64, 7, 64};

    rst = 1'b1; ena = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_coef = 12'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fields", {10'd0, cur_sym()}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    ena = 1'b0;
    #1 check("ena_low_in_ready", {31'd0, in_ready}, 32'd0);
    ena = 1'b1;

    for (int t = 0; t < 8; t++) begin
      clear_blk();
      cur_blk[0] = tbl[t].coef;
      exp_q.push_back(mk(0, tbl[t].size, tbl[t].amp, 1'b1, 1'b0));
      exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b1));
      drive_block((t % 2 == 0) ? 0 : 2, 0, 64);
      compare_block($sformatf("dc_tbl%0d", t));
    end

    // DC 0, AC1=-1, AC3=+3
    clear_blk();
    cur_blk[1] = -1; cur_blk[3] = 3;
    exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(mk(0, 1, 12'hFFE, 1'b0, 1'b0));
    exp_q.push_back(mk(1, 2, 3, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b1));
    drive_block(0, 0, 64);
    compare_block("mixed");

    // 34 zeros before AC35: two ZRLs, then run 2; the held coefficient takes one more stalled slot
    clear_blk();
    cur_blk[0] = 1; cur_blk[35] = 7;
    exp_q.push_back(mk(0, 1, 1, 1'b1, 1'b0));
    exp_q.push_back(mk(15, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(mk(15, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 3, 7, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b1));
    drive_block(0, 0, 64);
    check("zrl_stall_cycles", stall_cnt, 32'd3);
    compare_block("zrl2");

    // Most negative value at the last position after 62 zeros: no EOB
    clear_blk();
    cur_blk[0] = 1; cur_blk[63] = -2048;
    exp_q.push_back(mk(0, 1, 1, 1'b1, 1'b0));
    for (int r = 0; r < 3; r++) exp_q.push_back(mk(15, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(mk(14, 11, 12'h7FF, 1'b0, 1'b0));
    drive_block(0, 0, 64);
    compare_block("last_neg");

    // Same mixed block under toggling out_ready and ena gaps
    clear_blk();
    cur_blk[1] = -1; cur_blk[3] = 3;
    exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(mk(0, 1, 12'hFFE, 1'b0, 1'b0));
    exp_q.push_back(mk(1, 2, 3, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b1));
    drive_block(1, 0, 64);
    compare_block("backpressure");

    // Abandon a block at idx 20 with one ZRL pending
    clear_blk();
    cur_blk[0] = 3;
    exp_q.push_back(mk(0, 2, 3, 1'b1, 1'b0));
    drive_block(0, 0, 20);
    compare_block("pre_rst");
    @(posedge clk);
    #1 rst = 1'b1; ena = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_coef = 12'd4;
    @(negedge clk);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    clear_blk();
    cur_blk[0] = -7; cur_blk[5] = 100; cur_blk[63] = 1;
    model_block();
    @(posedge clk);
    #1 in_valid = 1'b1; in_coef = 12'(cur_blk[0]);
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("post_rst_dc_latency", {29'd0, out_valid, out_dc, 1'b0}, {29'd0, 1'b1, 1'b1, 1'b0});
    drive_block(2, 1, 64);
    compare_block("post_rst");

    for (int b = 0; b < 30; b++) begin
      int pz;
      int v;
      pz = (b % 3 == 0) ? 50 : ((b % 3 == 1) ? 90 : 98);
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 99) < pz) begin
          cur_blk[k] = 0;
        end else begin
          v = int'($urandom_range(0, 4095)) - 2048;
          if ($urandom_range(0, 1) == 1) v = v >>> 6;
          cur_blk[k] = (v == 0) ? 1 : v;
        end
      end
      if (b % 4 == 3) cur_blk[63] = int'($urandom_range(1, 9));
      model_block();
      drive_block((b % 5 == 0) ? 1 : 2, 0, 64);
      compare_block($sformatf("rand%0d", b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
